f2i_seq: RTL and testbench
==========================

# f2i_seq

Multi-cycle float-to-integer converter: takes an IEEE-754 single-precision operand and returns the signed 32-bit integer obtained by truncation toward zero, as a C cast does. It sits on the return path of the floating-point datapath, the inverse of the integer-to-float converter. It reuses the same 16/8/4/2/1 shift decomposition, spending one stage per clock, behind a valid/ready handshake on both sides.

## Interface
- `SAT_VALUE`, default `32'h8000_0000`: value driven on `d` for invalid conversions.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: operand `a` is valid.
- `in_ready` output 1: converter can accept an operand.
- `a` input 32: float operand `{sign, exponent[7:0], fraction[22:0]}`.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: consumer accepts the result.
- `d` output 32: signed integer result.
- `p_lost` output 1: nonzero fraction bits were discarded (inexact).
- `invalid` output 1: NaN, infinity, or magnitude out of int32 range.

## Operation
- Accept when `in_valid && in_ready`. `in_ready` = (state == IDLE), combinational from state.
- Decode the accepted `a`: s = a[31], e = a[30:23], f = a[22:0], m = {1'b1, f} (24 bits).
- Special cases, all resolved at accept with no SHIFT:
  - e < 127, including zero and denormals: d = 0, p_lost = |a[30:0], invalid = 0.
  - e ≥ 158, including Inf/NaN at e = 255:
    - a == 32'hCF00_0000: d = 32'h8000_0000, p_lost = 0, invalid = 0.
    - otherwise: d = SAT_VALUE, invalid = 1, p_lost = 0.
- Normal case, 127 ≤ e ≤ 157:
  - Working register w[31:0] = {8'b0, m}, sticky = 0.
  - If e ≥ 150: dir = left, sh = e − 150 (0..7).
  - Otherwise: dir = right, sh = 150 − e (1..23).
  - SHIFT stage i, for i = 4 down to 0: if sh[i], shift w by 2^i in direction dir.
  - For a right shift, OR the bits shifted out into sticky.
  - The left-shift result is at most 31 bits, so it cannot overflow.
  - NEG: d = s ? −w : w. p_lost = sticky. invalid = 0.
- FSM states: IDLE, SHIFT (5-count stage counter), NEG, DONE.
  - IDLE → DONE on accept of a special case.
  - IDLE → SHIFT on accept of a normal case; the counter loads 4.
  - SHIFT → SHIFT while counter ≠ 0, decrementing each cycle.
  - SHIFT → NEG when counter == 0.
  - NEG → DONE.
  - DONE → IDLE when out_ready is high.
- `out_valid` = (state == DONE), registered.
- `d`, `p_lost` and `invalid` are registered and held stable throughout DONE, regardless of the `a` and `in_valid` inputs.

## Timing
- Reset, sampled on a clk edge with rst_n = 0:
  - state = IDLE, counter = 0, w = 0, sticky = 0.
  - out_valid = 0, d = 0, p_lost = 0, invalid = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset asserted mid-operation (SHIFT, NEG or DONE) aborts the conversion. No result is ever presented for that operand.
- Latency, counted from the accept edge k:
  - Normal: out_valid high in the cycle after edge k+6 (5 SHIFT edges, 1 NEG edge).
  - Special: out_valid high in the cycle after edge k.
- Handshake:
  - The result transfers on the edge where out_valid && out_ready.
  - in_ready rises in the following cycle, so there is no same-cycle turnaround.
  - Throughput: one operand per 8 cycles (normal) or 2 cycles (special) with out_ready held high.
- in_valid while in_ready = 0 is ignored and consumes nothing. The upstream holds `a` until accepted.
- out_ready while out_valid = 0 has no effect.

## Test plan
- a = 32'h3F80_0000 (1.0) → d = 32'h0000_0001, p_lost = 0, invalid = 0. out_valid appears 6 cycles after accept.
- a = 32'hC049_0FDB (−3.14159) → d = 32'hFFFF_FFFD, p_lost = 1. a = 32'h4EFF_FFFF → d = 32'h7FFF_FF80, p_lost = 0.
- Range edges, all with 1-cycle latency:
  - a = 32'hCF00_0000 → d = 32'h8000_0000, invalid = 0.
  - a = 32'h4F00_0000 → d = SAT_VALUE, invalid = 1.
  - a = 32'h7FC0_0000 (NaN) → d = SAT_VALUE, invalid = 1.
- Small values:
  - a = 32'h3F00_0000 (0.5) → d = 0, p_lost = 1.
  - a = 32'h0000_0000 → d = 0, p_lost = 0.
  - a = 32'h8000_0001 (denormal) → d = 0, p_lost = 1.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles in DONE, with in_valid = 1 and `a` changing. Required: d, p_lost and invalid stay stable, in_ready = 0, nothing is accepted.
  - Then raise out_ready. Required: in_ready = 1 the next cycle.
- Reset and round-trip:
  - Drive rst_n = 0 for one edge during the 3rd SHIFT cycle. Required: out_valid = 0 and in_ready = 1 after that edge, with no stale result.
  - Then 1000 random integers with |x| < 2^24, converted with the integer-to-float converter and fed back through this block. Required: d equals x exactly and p_lost = 0 for every value.

Source files
------------

// File: rtl/f2i_seq.sv
// Multi-cycle IEEE-754 single to int32 converter (truncate toward zero).
// One 16/8/4/2/1 shift stage per clock, valid/ready on both sides.
module f2i_seq #(
  parameter logic [31:0] SAT_VALUE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        p_lost,
  output logic        invalid
);

  localparam int unsigned DW   = 32;
  localparam int unsigned EW   = 8;
  localparam int unsigned SHW  = 5;
  localparam int unsigned CNTW = 3;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_NEG, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNTW-1:0]   r_cnt;
  logic [DW-1:0]     r_w;
  logic              r_sticky;
  logic              r_dir_left;
  logic [SHW-1:0]    r_sh;
  logic              r_sign;

  logic              w_accept;
  logic [EW-1:0]     w_e;
  logic              w_small;
  logic              w_big;
  logic              w_left;
  logic [SHW-1:0]    w_sh;
  logic [SHW-1:0]    w_amt;
  logic [DW-1:0]     w_mask;
  logic              w_stage_en;
  logic [DW-1:0]     w_shifted;
  logic              w_lost;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid && in_ready;

  // Operand decode, evaluated at accept
  assign w_e     = a[30:23];
  assign w_small = (w_e < EW'(127));
  assign w_big   = (w_e >= EW'(158));
  assign w_left  = (w_e >= EW'(150));
  assign w_sh    = w_left ? SHW'(w_e - EW'(150)) : SHW'(EW'(150) - w_e);

  // Current shift stage: amount 2^cnt, enabled by the matching bit of sh
  assign w_amt      = SHW'(1) << r_cnt;
  assign w_mask     = (DW'(1) << w_amt) - DW'(1);
  assign w_stage_en = |(r_sh & (SHW'(1) << r_cnt));
  assign w_shifted  = r_dir_left ? (r_w << w_amt) : (r_w >> w_amt);
  assign w_lost     = |(r_w & w_mask);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = (w_small || w_big) ? S_DONE : S_SHIFT;
      S_SHIFT: if (r_cnt == '0) w_next_state = S_NEG;
      S_NEG:   w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_w        <= '0;
      r_sticky   <= 1'b0;
      r_dir_left <= 1'b0;
      r_sh       <= '0;
      r_sign     <= 1'b0;
      out_valid  <= 1'b0;
      d          <= '0;
      p_lost     <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      out_valid <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign <= a[31];
            if (w_small) begin
              d       <= '0;
              p_lost  <= |a[30:0];
              invalid <= 1'b0;
            end else if (w_big) begin
              p_lost <= 1'b0;
              if (a == 32'hCF00_0000) begin
                d       <= 32'h8000_0000;
                invalid <= 1'b0;
              end else begin
                d       <= SAT_VALUE;
                invalid <= 1'b1;
              end
            end else begin
              r_w        <= {8'b0, 1'b1, a[22:0]};
              r_sticky   <= 1'b0;
              r_dir_left <= w_left;
              r_sh       <= w_sh;
              r_cnt      <= CNTW'(4);
            end
          end
        end
        S_SHIFT: begin
          if (w_stage_en) begin
            r_w <= w_shifted;
            if (!r_dir_left) r_sticky <= r_sticky | w_lost;
          end
          if (r_cnt != '0) r_cnt <= r_cnt - CNTW'(1);
        end
        S_NEG: begin
          d       <= r_sign ? (DW'(0) - r_w) : r_w;
          p_lost  <= r_sticky;
          invalid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_f2i_seq.sv
// Self-checking bench for f2i_seq: directed vectors, backpressure, mid-op reset,
// random floats and an int->float->int round trip against an arithmetic model.
module tb_f2i_seq;

  localparam logic [31:0] SAT = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        p_lost;
  logic        invalid;

  int errors = 0;
  int checks = 0;

  f2i_seq #(.SAT_VALUE(SAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .d(d), .p_lost(p_lost),
    .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: value = 1.f * 2^(e-127), truncated toward zero; returns {invalid, p_lost, d}
  function automatic logic [33:0] ref_f2i(input logic [31:0] x);
    logic        s;
    int          e;
    longint      m;
    longint      mag;
    logic        lost;
    logic        inv;
    logic [31:0] r;
    s = x[31];
    e = int'(x[30:23]);
    m = longint'({1'b1, x[22:0]});
    lost = 1'b0;
    inv  = 1'b0;
    if (e < 127) begin
      r    = 32'd0;
      lost = (x[30:0] != 31'd0);
    end else if (e >= 158) begin
      if (x == 32'hCF00_0000) r = 32'h8000_0000;
      else begin
        r   = SAT;
        inv = 1'b1;
      end
    end else begin
      if (e >= 150) mag = m * (longint'(1) << (e - 150));
      else begin
        mag  = m / (longint'(1) << (150 - e));
        lost = (m % (longint'(1) << (150 - e))) != 0;
      end
      r = s ? 32'(-mag) : 32'(mag);
    end
    return {inv, lost, r};
  endfunction

  // Exact int->float for |x| < 2^24
  function automatic logic [31:0] i2f(input int x);
    int unsigned mag;
    int          p;
    logic [31:0] sh;
    if (x == 0) return 32'd0;
    mag = (x < 0) ? int'(-x) : x;
    p = 0;
    for (int i = 0; i < 24; i++) if (mag[i]) p = i;
    sh = mag << (23 - p);
    return {(x < 0), 8'(127 + p), sh[22:0]};
  endfunction

  // Offer one operand, wait for the result, check it, then drain it
  task automatic convert(input string tag, input logic [31:0] x);
    logic [33:0] exp;
    int          n;
    exp = ref_f2i(x);
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check({tag, "_inready"}, 32'(in_ready), 32'd1);
    a = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = $urandom;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check({tag, "_lat"}, 32'(n), (exp[33] || x[30:23] < 8'd127 || x == 32'hCF00_0000) ? 32'd0 : 32'd6);
    check({tag, "_d"}, d, exp[31:0]);
    check({tag, "_plost"}, 32'(p_lost), 32'(exp[32]));
    check({tag, "_inv"}, 32'(invalid), 32'(exp[33]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  logic [31:0] vec [9] = '{32'h3F80_0000, 32'hC049_0FDB, 32'h4EFF_FFFF, 32'hCF00_0000,
                           32'h4F00_0000, 32'h7FC0_0000, 32'h3F00_0000, 32'h0000_0000,
                           32'h8000_0001};
  logic [31:0] vec_d [9] = '{32'h0000_0001, 32'hFFFF_FFFD, 32'h7FFF_FF80, 32'h8000_0000,
                             SAT, SAT, 32'd0, 32'd0, 32'd0};

  initial begin
    logic [31:0] held_d;
    logic        held_p;
    logic        held_i;
    int          n;
    int          x;
    int unsigned mag;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 32'd0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_outs", {28'd0, out_valid, p_lost, invalid, in_ready}, 32'b0001);
    check("rst_d", d, 32'd0);

    // Directed vectors, cross-checked against hand-derived constants too
    for (int i = 0; i < 9; i++) begin
      convert($sformatf("vec%0d", i), vec[i]);
      check($sformatf("vec%0d_const", i), d, vec_d[i]);
    end

    // Backpressure: hold the result while upstream keeps offering operands
    a = 32'hC049_0FDB;
    in_valid = 1'b1;
    tick();
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("bp_valid", 32'(out_valid), 32'd1);
    held_d = d;
    held_p = p_lost;
    held_i = invalid;
    check("bp_d0", held_d, 32'hFFFF_FFFD);
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      tick();
      check("bp_hold", {d[31:0]}, held_d);
      check("bp_flags", {29'd0, p_lost, invalid, in_ready}, {29'd0, held_p, held_i, 1'b0});
      check("bp_ovalid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", {30'd0, out_valid, in_ready}, 32'b01);
    tick();
    tick();
    check("bp_no_extra", 32'(out_valid), 32'd0);

    // Reset during the third SHIFT cycle
    a = 32'h4EFF_FFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_state", {30'd0, out_valid, in_ready}, 32'b01);
    check("midrst_d", d, 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) n++;
    end
    check("midrst_stale", 32'(n), 32'd0);

    // Random bit patterns against the model
    for (int i = 0; i < 200; i++) convert("rnd", $urandom);

    // Round trip of exactly representable integers
    for (int i = 0; i < 1000; i++) begin
      mag = $urandom_range(0, (1 << 24) - 1);
      x = ($urandom_range(0, 1) == 1) ? -int'(mag) : int'(mag);
      convert("rt", i2f(x));
      check("rt_exact", d, 32'(x));
      check("rt_plost", 32'(p_lost), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
